// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, PC/IR/MAR/MDR, Y, HI/LO, 64-bit Z and ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier and divider; otherwise mul/div yield 0.
module data_path (
  input  logic        PCout,
  input  logic        ZHighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  OR,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Cin,
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut,
  output logic [31:0] IRq,
  output logic [31:0] MARq,
  output logic [31:0] R1q
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_NEG  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01101;
  localparam logic [4:0] OP_DIV  = 5'b01110;

  // R0 is hard-wired zero and never stored; entries 16/17 hold HI/LO so all
  // bus-loaded words share one load loop.
  localparam int unsigned RF_LAST = 17;

  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [31:0] rf_q [1:RF_LAST];
  logic [63:0] z_q;

  logic [31:0]        bus;
  logic [63:0]        alu_result;
  logic [RF_LAST:1]   rf_load;
  logic [4:0]         shamt;
  logic [63:0]        ror_w, rol_w;

  assign rf_load = {LOin, HIin, R15in, R14in, R13in, R12in, R11in, R10in, R9in,
                    R8in, R7in, R6in, R5in, R4in, R3in, R2in, R1in};

  // Fixed-priority bus source select.
  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    bus = '0;
    if (MDRout)        bus = mdr_q;
    else if (PCout)    bus = pc_q;
    else if (Zlowout)  bus = z_q[31:0];
    else if (ZHighout) bus = z_q[63:32];
    else if (R2out)    bus = rf_q[2];
    else if (R3out)    bus = rf_q[3];
    else if (R4out)    bus = rf_q[4];
    else if (R5out)    bus = rf_q[5];
    else if (R6out)    bus = rf_q[6];
    else if (R7out)    bus = rf_q[7];
  end

  assign BusMuxOut = bus;

  assign shamt = bus[4:0];
  assign ror_w = {y_q, y_q} >> shamt;
  assign rol_w = {y_q, y_q} << shamt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] mul_p;
  logic signed [31:0] div_q, div_r;

  assign mul_p = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
  assign div_q = $signed(y_q) / $signed(bus);
  assign div_r = $signed(y_q) % $signed(bus);
`endif

  always_comb begin
    alu_result = '0;
    case (OR)
      OP_ADD:  alu_result[31:0] = y_q + bus + {31'b0, Cin};
      OP_SUB:  alu_result[31:0] = y_q - bus - {31'b0, Cin};
      OP_AND:  alu_result[31:0] = y_q & bus;
      OP_OR:   alu_result[31:0] = y_q | bus;
      OP_SHR:  alu_result[31:0] = y_q >> shamt;
      OP_SHRA: alu_result[31:0] = $unsigned($signed(y_q) >>> shamt);
      OP_SHL:  alu_result[31:0] = y_q << shamt;
      OP_ROR:  alu_result[31:0] = ror_w[31:0];
      OP_ROL:  alu_result[31:0] = rol_w[63:32];
      OP_NEG:  alu_result[31:0] = 32'd0 - bus;
      OP_NOT:  alu_result[31:0] = ~bus;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  alu_result = $unsigned(mul_p);
      OP_DIV: begin
        // Divide-by-zero: all-ones quotient, dividend passed through as remainder.
        if (bus == 32'd0) alu_result = {y_q, 32'hFFFF_FFFF};
        else              alu_result = {$unsigned(div_r), $unsigned(div_q)};
      end
`else
      OP_MUL:  alu_result = '0;
      OP_DIV:  alu_result = '0;
`endif
      default: alu_result = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge bus.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      // NOTE: the register file is reset entry by entry, which keeps it in flops rather than a RAM macro.
      for (int i = 1; i <= RF_LAST; i++) rf_q[i] <= '0;
    end else begin
      if (IncPC)     pc_q <= pc_q + 32'd1;
      else if (PCin) pc_q <= bus;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      if (Yin)   y_q   <= bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (ZLowIn)  z_q[31:0]  <= alu_result[31:0];
      if (ZHighIn) z_q[63:32] <= alu_result[63:32];
      for (int i = 1; i <= RF_LAST; i++) begin
        if (rf_load[i]) rf_q[i] <= bus;
      end
    end
  end

  assign IRq  = ir_q;
  assign MARq = mar_q;
  assign R1q  = rf_q[1];

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed transfers with literal expectations, then random control steps
// compared every cycle against a behavioural model of the datapath.
module tb_data_path;

  typedef struct packed {
    logic        pc_out, zhigh_out, zlow_out, mdr_out;
    logic [7:2]  r_out;
    logic        mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, rd;
    logic [4:0]  op;
    logic [15:1] r_in;
    logic        hi_in, lo_in, zhigh_in, zlow_in, cin;
  } ctrl_t;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] Mdatain;
  ctrl_t       ctl;
  logic [31:0] BusMuxOut, IRq, MARq, R1q;

  int n_checks = 0;
  int n_err    = 0;
  bit checking = 1'b0;

  // Behavioural model state
  logic [31:0] m_r [0:15];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
  logic [63:0] m_z;

  always #5 Clock = ~Clock;

  data_path dut (
    .PCout(ctl.pc_out), .ZHighout(ctl.zhigh_out), .Zlowout(ctl.zlow_out), .MDRout(ctl.mdr_out),
    .R2out(ctl.r_out[2]), .R3out(ctl.r_out[3]), .R4out(ctl.r_out[4]),
    .R5out(ctl.r_out[5]), .R6out(ctl.r_out[6]), .R7out(ctl.r_out[7]),
    .MARin(ctl.mar_in), .PCin(ctl.pc_in), .MDRin(ctl.mdr_in), .IRin(ctl.ir_in), .Yin(ctl.y_in),
    .IncPC(ctl.inc_pc), .Read(ctl.rd), .OR(ctl.op),
    .R1in(ctl.r_in[1]), .R2in(ctl.r_in[2]), .R3in(ctl.r_in[3]), .R4in(ctl.r_in[4]),
    .R5in(ctl.r_in[5]), .R6in(ctl.r_in[6]), .R7in(ctl.r_in[7]), .R8in(ctl.r_in[8]),
    .R9in(ctl.r_in[9]), .R10in(ctl.r_in[10]), .R11in(ctl.r_in[11]), .R12in(ctl.r_in[12]),
    .R13in(ctl.r_in[13]), .R14in(ctl.r_in[14]), .R15in(ctl.r_in[15]),
    .HIin(ctl.hi_in), .LOin(ctl.lo_in), .ZHighIn(ctl.zhigh_in), .ZLowIn(ctl.zlow_in),
    .Cin(ctl.cin), .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .IRq(IRq), .MARq(MARq), .R1q(R1q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_bus(input ctrl_t c);
    if (c.mdr_out)   return m_mdr;
    if (c.pc_out)    return m_pc;
    if (c.zlow_out)  return m_z[31:0];
    if (c.zhigh_out) return m_z[63:32];
    for (int i = 2; i <= 7; i++) if (c.r_out[i]) return m_r[i];
    return 32'd0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
    int unsigned n;
    logic [31:0] r;
    longint p;
    n = b[4:0];
    r = a;
    case (op)
      5'b00000: return {32'd0, a + b + 32'(cin)};
      5'b00001: return {32'd0, a - b - 32'(cin)};
      5'b01010: return {32'd0, a & b};
      5'b01011: return {32'd0, a | b};
      5'b00100: return {32'd0, a >> n};
      5'b00101: return {32'd0, $unsigned($signed(a) >>> n)};
      5'b00110: return {32'd0, a << n};
      5'b00111: begin repeat (n) r = {r[0], r[31:1]}; return {32'd0, r}; end
      5'b01000: begin repeat (n) r = {r[30:0], r[31]}; return {32'd0, r}; end
      5'b01001: return {32'd0, 32'd0 - b};
      5'b01100: return {32'd0, ~b};
`ifdef DATAPATH_MULDIV_EN
      5'b01101: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      5'b01110: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
`endif
      default: return 64'd0;
    endcase
  endfunction

  // Model advances on the same edge as the DUT, from the pre-edge model state and controls.
  always @(posedge Clock) begin
    logic [31:0] b;
    logic [63:0] res;
    if (Clear) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_hi = 0; m_lo = 0; m_z = 0;
    end else begin
      b   = model_bus(ctl);
      res = model_alu(ctl.op, m_y, b, ctl.cin);
      if (ctl.inc_pc)     m_pc = m_pc + 1;
      else if (ctl.pc_in) m_pc = b;
      if (ctl.ir_in)  m_ir  = b;
      if (ctl.mar_in) m_mar = b;
      if (ctl.y_in)   m_y   = b;
      if (ctl.mdr_in) m_mdr = ctl.rd ? Mdatain : b;
      if (ctl.hi_in)  m_hi  = b;
      if (ctl.lo_in)  m_lo  = b;
      if (ctl.zlow_in)  m_z[31:0]  = res[31:0];
      if (ctl.zhigh_in) m_z[63:32] = res[63:32];
      for (int i = 1; i <= 15; i++) if (ctl.r_in[i]) m_r[i] = b;
    end
  end

  always @(negedge Clock) begin
    if (checking) begin
      check("bus", BusMuxOut, model_bus(ctl));
      check("irq", IRq, m_ir);
      check("marq", MARq, m_mar);
      check("r1q", R1q, m_r[1]);
    end
  end

  task automatic step(input ctrl_t c, input logic [31:0] md);
    ctl = c;
    Mdatain = md;
    @(posedge Clock);
    #1;
  endtask

  task automatic peek(input ctrl_t c);
    ctl = c;
    #1;
  endtask

  // Memory word -> MDR -> destination(s) selected by dst.
  task automatic load(input ctrl_t dst, input logic [31:0] v);
    ctrl_t c;
    c = '0; c.rd = 1'b1; c.mdr_in = 1'b1;
    step(c, v);
    c = dst; c.mdr_out = 1'b1;
    step(c, 32'd0);
  endtask

  // Y <- ya, MDR <- b, then Z <- alu(op); leaves MDR driving the bus during the ALU step.
  task automatic alu_op(input logic [31:0] ya, input logic [31:0] b, input logic [4:0] op);
    ctrl_t c;
    c = '0; c.y_in = 1'b1;
    load(c, ya);
    c = '0; c.rd = 1'b1; c.mdr_in = 1'b1;
    step(c, b);
    c = '0; c.mdr_out = 1'b1; c.op = op; c.zlow_in = 1'b1; c.zhigh_in = 1'b1;
    step(c, 32'd0);
  endtask

  task automatic check_z(input string name, input logic [31:0] lo, input logic [31:0] hi);
    ctrl_t c;
    c = '0; c.zlow_out = 1'b1;  peek(c); check({name, "_lo"}, BusMuxOut, lo);
    c = '0; c.zhigh_out = 1'b1; peek(c); check({name, "_hi"}, BusMuxOut, hi);
  endtask

  initial begin
    ctrl_t c;
    logic [31:0] b;
    int k;
    ctl = '0; Clear = 1'b1; Mdatain = '0;
    repeat (2) @(posedge Clock);
    #1;
    Clear = 1'b0;
    check("rst_irq", IRq, 32'd0);
    check("rst_marq", MARq, 32'd0);
    check("rst_r1q", R1q, 32'd0);
    check("rst_bus", BusMuxOut, 32'd0);
    checking = 1'b1;

    // Loads through MDR
    c = '0; c.r_in[2] = 1'b1; load(c, 32'h12);
    c = '0; c.r_out[2] = 1'b1; peek(c); check("r2_load", BusMuxOut, 32'h12);
    c = '0; c.r_in[3] = 1'b1; load(c, 32'h14);
    c = '0; c.r_in[1] = 1'b1; load(c, 32'h18);
    check("r1_load", R1q, 32'h18);

    // R1 <- R2 | R3
    c = '0; c.r_out[2] = 1'b1; c.y_in = 1'b1; step(c, 0);
    c = '0; c.r_out[3] = 1'b1; c.op = 5'b01011; c.zlow_in = 1'b1; step(c, 0);
    c = '0; c.zlow_out = 1'b1; c.r_in[1] = 1'b1; step(c, 0);
    check("or_r1", R1q, 32'h16);

    // Instruction fetch, PC -> MAR with increment
    c = '0; c.ir_in = 1'b1; load(c, 32'h2891_8000);
    check("ir_fetch", IRq, 32'h2891_8000);
    c = '0; c.pc_in = 1'b1; load(c, 32'd7);
    c = '0; c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; step(c, 0);
    check("mar_pc", MARq, 32'd7);
    c = '0; c.pc_out = 1'b1; peek(c); check("pc_inc", BusMuxOut, 32'd8);

    // ALU corner cases
    alu_op(32'hFFFF_FFFF, 32'd1, 5'b00000);
    check_z("add_wrap", 32'd0, 32'd0);
    alu_op(32'h8000_0001, 32'd4, 5'b00111);
    check_z("ror", 32'h1800_0000, 32'd0);
    alu_op(32'hFFFF_FFFE, 32'd3, 5'b01101);
`ifdef DATAPATH_MULDIV_EN
    check_z("mul", 32'hFFFF_FFFA, 32'hFFFF_FFFF);
`else
    check_z("mul_off", 32'd0, 32'd0);
`endif
    alu_op(32'd7, 32'd2, 5'b01110);
`ifdef DATAPATH_MULDIV_EN
    check_z("div", 32'd3, 32'd1);
`else
    check_z("div_off", 32'd0, 32'd0);
`endif
    alu_op(32'd7, 32'd0, 5'b01110);
`ifdef DATAPATH_MULDIV_EN
    check_z("div0", 32'hFFFF_FFFF, 32'd7);
`else
    check_z("div0_off", 32'd0, 32'd0);
`endif

    // Bus priority and idle bus
    c = '0; c.rd = 1'b1; c.mdr_in = 1'b1; step(c, 32'hA5A5_0000);
    c = '0; c.mdr_out = 1'b1; c.pc_out = 1'b1; peek(c); check("bus_prio", BusMuxOut, 32'hA5A5_0000);
    c = '0; peek(c); check("bus_idle", BusMuxOut, 32'd0);

    // Clear overrides a concurrent load
    Clear = 1'b1;
    c = '0; c.mdr_out = 1'b1; c.r_in[1] = 1'b1; step(c, 0);
    Clear = 1'b0;
    check("clr_r1q", R1q, 32'd0);
    check("clr_irq", IRq, 32'd0);
    check("clr_marq", MARq, 32'd0);
    c = '0; c.pc_out = 1'b1; peek(c); check("clr_pc", BusMuxOut, 32'd0);

    // Random control steps against the model
    for (int it = 0; it < 800; it++) begin
      c = '0;
      k = $urandom_range(0, 2);
      repeat (k) begin
        case ($urandom_range(0, 9))
          0: c.pc_out = 1'b1;
          1: c.zhigh_out = 1'b1;
          2: c.zlow_out = 1'b1;
          3: c.mdr_out = 1'b1;
          default: c.r_out[$urandom_range(2, 7)] = 1'b1;
        endcase
      end
      c.mar_in   = ($urandom_range(0, 3) == 0);
      c.pc_in    = ($urandom_range(0, 5) == 0);
      c.mdr_in   = ($urandom_range(0, 2) == 0);
      c.ir_in    = ($urandom_range(0, 5) == 0);
      c.y_in     = ($urandom_range(0, 3) == 0);
      c.inc_pc   = ($urandom_range(0, 7) == 0);
      c.rd       = $urandom_range(0, 1) == 1;
      c.op       = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      c.r_in     = 15'($urandom) & 15'($urandom);
      c.hi_in    = ($urandom_range(0, 5) == 0);
      c.lo_in    = ($urandom_range(0, 5) == 0);
      c.zhigh_in = $urandom_range(0, 1) == 1;
      c.zlow_in  = $urandom_range(0, 1) == 1;
      c.cin      = $urandom_range(0, 1) == 1;
      b = model_bus(c);
      if (c.op == 5'b01110 && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF) c.op = 5'b00000;
      Clear = ($urandom_range(0, 59) == 0);
      step(c, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
    end
    Clear = 1'b0;
    ctl = '0;
    @(negedge Clock);
    checking = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
